// File: rtl/rgmii_tx_gen.sv
`default_nettype none
// ============================================================================
//  Module   : rgmii_tx_gen
//  Purpose  : RGMII transmit generator. Turns a GMII-style MAC TX stream into
//             DDR register inputs (d1 = rising half, d2 = falling half) for
//             the TX clock, TXD nibbles and TX_CTL. All three speeds run from
//             one clock: 1000M forwards every cycle, 10M/100M divide the
//             clock down and hand the MAC a clock-enable qualifier.
//  Options  : RGMII_TX_SPEED_DEFER_EN - hold a speed change back until the
//             held tx_en is low, so a frame is never split across speeds.
//  Revision : 1.0 - initial release
// ============================================================================
module rgmii_tx_gen #(
    parameter int DIV_10M   = 50,
    parameter int DIV_100M  = 5,
    parameter int BYTE_MODE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] speed,
    input  logic [7:0] mac_gmii_txd,
    input  logic       mac_gmii_tx_en,
    input  logic       mac_gmii_tx_er,
    output logic       mac_gmii_tx_clk_en,
    output logic       mac_gmii_tx_rst,
    output logic       tx_clk_d1,
    output logic       tx_clk_d2,
    output logic [3:0] txd_d1,
    output logic [3:0] txd_d2,
    output logic       tx_ctl_d1,
    output logic       tx_ctl_d2,
    output logic [1:0] active_speed
);

    localparam int CW = $clog2(DIV_10M);
    localparam logic [CW-1:0] LAST_10M  = CW'(DIV_10M - 1);
    localparam logic [CW-1:0] LAST_100M = CW'(DIV_100M - 1);
    localparam logic [CW-1:0] HALF_10M  = CW'(DIV_10M / 2);
    localparam logic [CW-1:0] HALF_100M = CW'(DIV_100M / 2);
    localparam logic [1:0]    SPEED_1G  = 2'b10;

    logic [CW-1:0] cnt;
    logic          phase;
    logic [7:0]    hold_txd;
    logic          hold_en;
    logic          hold_er;
    logic [3:0]    rst_sr;

    logic          is_gig;
    logic          at_last;
    logic          clk_high;
    logic          boundary;
    logic          allow_update;
    logic          do_update;
    logic [1:0]    req_speed;
    logic [CW-1:0] period_last;
    logic [CW-1:0] period_half;
    logic [3:0]    nibble;

    // Period decode, speed-change decision and MAC sample qualifier
    always_comb begin
        is_gig      = active_speed[1];
        period_last = (active_speed == 2'b00) ? LAST_10M : LAST_100M;
        period_half = (active_speed == 2'b00) ? HALF_10M : HALF_100M;
        at_last     = !is_gig && (cnt == period_last);
        clk_high    = (cnt >= period_half);
        // 2'b11 is folded onto 1000M so it compares equal to an active 1000M
        req_speed   = speed[1] ? SPEED_1G : speed;
        // Changes land only at the end of a high phase (or any 1000M cycle),
        // so the next low phase always starts fresh and no runt pulse appears
        boundary    = is_gig || at_last;
`ifdef RGMII_TX_SPEED_DEFER_EN
        allow_update = !hold_en;
`else
        allow_update = 1'b1;
`endif
        do_update   = boundary && (req_speed != active_speed) && allow_update;
        // Byte mode consumes one byte per two nibble periods (phase 1 ends it)
        mac_gmii_tx_clk_en = rst || is_gig ||
                             (at_last && ((BYTE_MODE == 0) || phase));
        nibble      = ((BYTE_MODE != 0) && phase) ? hold_txd[7:4] : hold_txd[3:0];
    end

    // Period counter, byte phase and active speed
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            phase        <= 1'b0;
            active_speed <= SPEED_1G;
        end else if (do_update) begin
            cnt          <= '0;
            phase        <= 1'b0;
            active_speed <= req_speed;
        end else if (is_gig) begin
            cnt          <= '0;
        end else if (at_last) begin
            cnt          <= '0;
            phase        <= ~phase;
        end else begin
            cnt          <= cnt + 1'b1;
        end
    end

    // Capture MAC data whenever the qualifier is high; cleared by reset so a
    // frame cut by reset cannot leak out afterwards
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_txd <= 8'h00;
            hold_en  <= 1'b0;
            hold_er  <= 1'b0;
        end else if (mac_gmii_tx_clk_en) begin
            hold_txd <= mac_gmii_txd;
            hold_en  <= mac_gmii_tx_en;
            hold_er  <= mac_gmii_tx_er;
        end
    end

    // DDR output registers: clock pattern, nibbles and TX_CTL encoding
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_clk_d1 <= 1'b1;
            tx_clk_d2 <= 1'b0;
            txd_d1    <= 4'h0;
            txd_d2    <= 4'h0;
            tx_ctl_d1 <= 1'b0;
            tx_ctl_d2 <= 1'b0;
        end else if (is_gig) begin
            tx_clk_d1 <= 1'b1;
            tx_clk_d2 <= 1'b0;
            txd_d1    <= hold_txd[3:0];
            txd_d2    <= hold_txd[7:4];
            tx_ctl_d1 <= hold_en;
            tx_ctl_d2 <= hold_en ^ hold_er;
        end else begin
            tx_clk_d1 <= clk_high;
            tx_clk_d2 <= clk_high;
            txd_d1    <= nibble;
            txd_d2    <= nibble;
            tx_ctl_d1 <= clk_high ? (hold_en ^ hold_er) : hold_en;
            tx_ctl_d2 <= clk_high ? (hold_en ^ hold_er) : hold_en;
        end
    end

    // MAC reset stretcher: stays high three cycles beyond rst
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_sr <= 4'b1111;
        end else begin
            rst_sr <= {rst_sr[2:0], 1'b0};
        end
    end

    assign mac_gmii_tx_rst = rst_sr[3];

endmodule
`default_nettype wire

// File: doc/rgmii_tx_gen.md
RGMII_TX_GEN -- requirements
Module: rgmii_tx_gen

Interface
REQ-001 SHALL have parameter DIV_10M, default 50, clk cycles per 10M RGMII TX clock period (even, >=4).
REQ-002 SHALL have parameter DIV_100M, default 5, clk cycles per 100M TX clock period (>=3).
REQ-003 SHALL have parameter BYTE_MODE, default 0; when 1, in 10M/100M the MAC supplies full bytes, which the block serialises into nibbles.
REQ-004 SHALL have port clk, input, 1, single clock for all logic (125 MHz for 1000M).
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port speed, input, 2, requested speed: 00=10M, 01=100M, 1x=1000M.
REQ-007 SHALL have ports mac_gmii_txd (input, 8), mac_gmii_tx_en (input, 1) and mac_gmii_tx_er (input, 1), the GMII transmit data and controls.
REQ-008 SHALL have port mac_gmii_tx_clk_en, output, 1, qualifier marking the cycle in which MAC inputs are sampled.
REQ-009 SHALL have port mac_gmii_tx_rst, output, 1, reset for the MAC TX logic.
REQ-010 SHALL have ports tx_clk_d1 and tx_clk_d2, output, 1 each, rising-half and falling-half values for the external TX clock DDR output.
REQ-011 SHALL have ports txd_d1 and txd_d2, output, 4 each, rising-half and falling-half nibbles for the data DDR output.
REQ-012 SHALL have ports tx_ctl_d1 and tx_ctl_d2, output, 1 each, rising-half and falling-half TX_CTL values.
REQ-013 SHALL have port active_speed, output, 2, speed currently in effect.

Function
REQ-014 SHALL keep a period counter cnt running 0..DIV-1 for the active speed (DIV_10M or DIV_100M); width is clog2(DIV_10M); cnt wraps to 0 after DIV-1.
REQ-015 In 10M/100M, SHALL drive tx_clk_d1 = tx_clk_d2 = 1 for cnt >= DIV/2 (floor), and 0 otherwise.
REQ-016 In 1000M, SHALL drive tx_clk_d1=1, tx_clk_d2=0 and mac_gmii_tx_clk_en=1 every cycle, and hold cnt at 0.
REQ-017 In 10M/100M with BYTE_MODE=0, SHALL assert mac_gmii_tx_clk_en for one cycle when cnt==DIV-1.
REQ-018 In 10M/100M with BYTE_MODE=1, SHALL assert mac_gmii_tx_clk_en only in the cnt==DIV-1 cycle of every second period (a phase bit toggles at each wrap).
REQ-019 SHALL capture txd, tx_en and tx_er into holding registers in every cycle where mac_gmii_tx_clk_en=1; all d1/d2 outputs are registers, so output latency is 1 clk after capture.
REQ-020 In 1000M, SHALL output txd_d1 = txd[3:0], txd_d2 = txd[7:4], tx_ctl_d1 = tx_en and tx_ctl_d2 = tx_en XOR tx_er.
REQ-021 In 10M/100M, SHALL drive txd_d1 = txd_d2 = the held nibble for the whole period.
REQ-021a For the held nibble: with BYTE_MODE=0 it is held txd[3:0]; with BYTE_MODE=1 it is txd[3:0] in the first period and txd[7:4] in the second.
REQ-022 In 10M/100M, SHALL drive tx_ctl_d1 = tx_ctl_d2 = tx_en while the clock is low, and tx_en XOR tx_er while the clock is high.
REQ-023 SHALL update active_speed from speed only at a period boundary: the cnt==DIV-1 cycle in 10M/100M, or any cycle in 1000M. On update, cnt and the phase bit SHALL go to 0.
REQ-024 SHALL treat a speed input that is unchanged or equal to active_speed as a no-op; speed=11 SHALL be treated as 1000M.
REQ-025 An update of active_speed SHALL never produce a TX clock high or low phase shorter than the shorter of the old and new half periods.

Reset
REQ-026 While rst=1 the block SHALL hold these values: cnt=0, phase=0, active_speed=10, tx_clk_d1=1, tx_clk_d2=0, txd_d1/d2=0, tx_ctl_d1/d2=0, mac_gmii_tx_clk_en=1.
REQ-027 mac_gmii_tx_rst SHALL be 1 during rst and for 3 clk cycles after rst deasserts (4-bit shift register loaded with 1111), then 0.
REQ-028 A reset asserted mid-frame SHALL take effect on the next clk edge; no partial nibble SHALL be emitted after it.

Configuration
REQ-029 With macro RGMII_TX_SPEED_DEFER_EN defined, an active_speed update SHALL additionally require held tx_en=0. A speed request made mid-frame SHALL then wait for the first boundary after frame end.
REQ-030 Without RGMII_TX_SPEED_DEFER_EN, updates SHALL follow REQ-023 alone.

Verification
REQ-031 1000M, txd=A5, en=1, er=0 -> next cycle: txd_d1=5, txd_d2=A, ctl_d1=1, ctl_d2=1; er=1 -> ctl_d2=0.
REQ-032 100M, DIV_100M=5 -> clk_en high 1 of every 5 cycles; tx_clk high for cnt 2..4 and low for cnt 0..1; txd_d1=txd_d2=held low nibble.
REQ-033 10M, BYTE_MODE=1, txd=3C -> clk_en every 100 cycles; the first period outputs C and the second outputs 3.
REQ-034 100M idle, then er=1, en=0 -> ctl=0 while clock low, 1 while clock high.
REQ-035 With DEFER_EN, change speed from 100M to 1000M mid-frame -> active_speed stays 01 until tx_en is held 0, then becomes 10 at the next boundary; without DEFER_EN it changes at the next boundary.
REQ-036 Assert rst mid-frame at 10M -> outputs go to REQ-026 values next cycle; mac_gmii_tx_rst is high through rst plus 3 cycles.
